// File: rtl/idv_osc_meas_ctl.sv
// ----------------------------------------------------------------------------
// idv_osc_meas_ctl
//
// Measurement controller for the IDV ring-oscillator bank. It wakes the bank,
// enables one oscillator at a time, lets it warm up, then counts rising
// edges of the bank's pre-divided output over a programmable window of
// reference clocks. One result is produced per oscillator, either for a
// single index or for a sweep from osc_sel up to NOSC.
//
// Ports:
//   idvdebug_clki  reference clock, all state updates on its rising edge
//   idvrst_b       asynchronous active-low reset
//   start          request, sampled only while idle
//   abort          terminate the current operation, return to idle
//   sweep_mode     0: measure osc_sel only, 1: measure osc_sel..NOSC
//   osc_sel        first (or only) oscillator index, valid range 1..NOSC
//   win_len        window length in reference clocks (0 acts as 1)
//   osc_div_in     divided oscillator output, asynchronous to the clock
//   enosc          one-hot oscillator enable, bit i-1 enables oscillator i
//   sleep_b        bank awake while an operation is active
//   busy           operation in progress
//   cnt_valid      single-cycle result strobe
//   cnt_data       edge count (held until the next result)
//   cnt_sel        oscillator index belonging to cnt_data (held)
//   cnt_ovf        counter saturated during that window (held)
//   done           asserted with the final result of an operation
//   sel_err        one-cycle pulse after a start with an out-of-range index
// ----------------------------------------------------------------------------
module idv_osc_meas_ctl #(
   parameter int NOSC        = 63,
   parameter int SEL_W       = 7,
   parameter int CNT_W       = 16,
   parameter int WIN_W       = 16,
   parameter int SETTLE_CYC  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             idvdebug_clki,
   input  logic             idvrst_b,
   input  logic             start,
   input  logic             abort,
   input  logic             sweep_mode,
   input  logic [SEL_W-1:0] osc_sel,
   input  logic [WIN_W-1:0] win_len,
   input  logic             osc_div_in,
   output logic [NOSC-1:0]  enosc,
   output logic             sleep_b,
   output logic             busy,
   output logic             cnt_valid,
   output logic [CNT_W-1:0] cnt_data,
   output logic [SEL_W-1:0] cnt_sel,
   output logic             cnt_ovf,
   output logic             done,
   output logic             sel_err
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SETTLE  = 2'd1,
      S_MEASURE = 2'd2,
      S_REPORT  = 2'd3
   } state_t;

   // One down-counter serves both the settle phase and the window, so it
   // must be wide enough for either load value.
   localparam int TMR_W = (WIN_W > $clog2(SETTLE_CYC + 1)) ? WIN_W : $clog2(SETTLE_CYC + 1);
   localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
   localparam logic [SEL_W-1:0] NOSC_SEL    = SEL_W'(NOSC);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   state_t                 state_q, state_d;
   logic [SEL_W-1:0]       cur_q, cur_d;
   logic                   sweep_q, sweep_d;
   logic [WIN_W-1:0]       win_q, win_d;
   logic [TMR_W-1:0]       tmr_q, tmr_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   ovf_q, ovf_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic [CNT_W-1:0]       res_data_q, res_data_d;
   logic [SEL_W-1:0]       res_sel_q, res_sel_d;
   logic                   res_ovf_q, res_ovf_d;
   logic                   sel_err_q, sel_err_d;

   logic                   sync_out;
   logic                   edge_det;
   logic                   sel_ok;
   logic                   last_osc;
   logic [WIN_W-1:0]       win_m1;
   logic [CNT_W-1:0]       cnt_inc;
   logic [CNT_W-1:0]       cnt_nxt;
   logic                   ovf_nxt;

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign edge_det = sync_out & ~prev_q;
   assign sel_ok   = (osc_sel != '0) && (osc_sel <= NOSC_SEL);
   assign last_osc = !sweep_q || (cur_q >= NOSC_SEL);
   assign win_m1   = (win_q == '0) ? '0 : (win_q - WIN_W'(1));
   assign cnt_inc  = cnt_q + CNT_W'(1);

   // Saturating edge count for the current measure cycle.
   always_comb begin
      cnt_nxt = cnt_q;
      ovf_nxt = ovf_q;
      if (edge_det && (cnt_q != CNT_MAX)) begin
         cnt_nxt = cnt_inc;
         ovf_nxt = ovf_q | (cnt_inc == CNT_MAX);
      end
   end

   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      sweep_d    = sweep_q;
      win_d      = win_q;
      tmr_d      = tmr_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      res_data_d = res_data_q;
      res_sel_d  = res_sel_q;
      res_ovf_d  = res_ovf_q;
      sel_err_d  = 1'b0;
      prev_d     = sync_out;
      sync_d[0]  = osc_div_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end

      unique case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               if (sel_ok) begin
                  cur_d   = osc_sel;
                  sweep_d = sweep_mode;
                  win_d   = win_len;
                  tmr_d   = SETTLE_LOAD;
                  state_d = S_SETTLE;
               end else begin
                  sel_err_d = 1'b1;
               end
            end
         end
         S_SETTLE: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (tmr_q == '0) begin
               tmr_d   = TMR_W'(win_m1);
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = S_MEASURE;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         S_MEASURE: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_nxt;
               ovf_d = ovf_nxt;
               if (tmr_q == '0) begin
                  // Result registers load on the last window cycle, including
                  // that cycle's edge, so they are stable during REPORT.
                  res_data_d = cnt_nxt;
                  res_sel_d  = cur_q;
                  res_ovf_d  = ovf_nxt;
                  state_d    = S_REPORT;
               end else begin
                  tmr_d = tmr_q - TMR_W'(1);
               end
            end
         end
         S_REPORT: begin
            if (!abort && !last_osc) begin
               cur_d   = cur_q + SEL_W'(1);
               tmr_d   = SETTLE_LOAD;
               state_d = S_SETTLE;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge idvdebug_clki or negedge idvrst_b) begin
      if (!idvrst_b) begin
         state_q    <= S_IDLE;
         cur_q      <= '0;
         sweep_q    <= 1'b0;
         win_q      <= '0;
         tmr_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         sync_q     <= '0;
         prev_q     <= 1'b0;
         res_data_q <= '0;
         res_sel_q  <= '0;
         res_ovf_q  <= 1'b0;
         sel_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         sweep_q    <= sweep_d;
         win_q      <= win_d;
         tmr_q      <= tmr_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         sync_q     <= sync_d;
         prev_q     <= prev_d;
         res_data_q <= res_data_d;
         res_sel_q  <= res_sel_d;
         res_ovf_q  <= res_ovf_d;
         sel_err_q  <= sel_err_d;
      end
   end

   // Enable is dropped in REPORT so consecutive sweep oscillators never
   // overlap.
   always_comb begin
      enosc = '0;
      if ((state_q == S_SETTLE) || (state_q == S_MEASURE)) begin
         for (int unsigned i = 0; i < NOSC; i++) begin
            enosc[i] = (cur_q == SEL_W'(i + 1));
         end
      end
   end

   assign sleep_b   = (state_q != S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign cnt_valid = (state_q == S_REPORT);
   assign done      = (state_q == S_REPORT) && last_osc && !abort;
   assign cnt_data  = res_data_q;
   assign cnt_sel   = res_sel_q;
   assign cnt_ovf   = res_ovf_q;
   assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_idv_osc_meas_ctl.sv
module tb_idv_osc_meas_ctl;

   localparam int NOSC  = 63;
   localparam int SEL_W = 7;
   localparam int CNT_W = 16;
   localparam int WIN_W = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start, abort, sweep_mode, osc;
   logic [SEL_W-1:0] osc_sel;
   logic [WIN_W-1:0] win_len;

   logic [NOSC-1:0]  enosc;
   logic             sleep_b, busy, cnt_valid, cnt_ovf, done, sel_err;
   logic [CNT_W-1:0] cnt_data;
   logic [SEL_W-1:0] cnt_sel;

   logic [NOSC-1:0]  enosc4;
   logic             sleep_b4, busy4, cnt_valid4, cnt_ovf4, done4, sel_err4;
   logic [3:0]       cnt_data4;
   logic [SEL_W-1:0] cnt_sel4;

   int errors = 0;
   int checks = 0;
   int osc_period = 0;
   int ph = 0;

   idv_osc_meas_ctl u_dut (
      .idvdebug_clki(clk), .idvrst_b(rst_n), .start(start), .abort(abort),
      .sweep_mode(sweep_mode), .osc_sel(osc_sel), .win_len(win_len),
      .osc_div_in(osc), .enosc(enosc), .sleep_b(sleep_b), .busy(busy),
      .cnt_valid(cnt_valid), .cnt_data(cnt_data), .cnt_sel(cnt_sel),
      .cnt_ovf(cnt_ovf), .done(done), .sel_err(sel_err)
   );

   idv_osc_meas_ctl #(.CNT_W(4)) u_dut4 (
      .idvdebug_clki(clk), .idvrst_b(rst_n), .start(start), .abort(abort),
      .sweep_mode(sweep_mode), .osc_sel(osc_sel), .win_len(win_len),
      .osc_div_in(osc), .enosc(enosc4), .sleep_b(sleep_b4), .busy(busy4),
      .cnt_valid(cnt_valid4), .cnt_data(cnt_data4), .cnt_sel(cnt_sel4),
      .cnt_ovf(cnt_ovf4), .done(done4), .sel_err(sel_err4)
   );

   always #5 clk = ~clk;

   // Square wave with a period of osc_period clocks, changing mid-cycle.
   always @(posedge clk) begin
      #3;
      if (osc_period == 0) begin
         ph  = 0;
         osc = 1'b0;
      end else begin
         ph  = (ph + 1 >= osc_period) ? 0 : ph + 1;
         osc = (ph < osc_period / 2);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) tick();
      checks++; if (enosc !== '0) begin errors++; $display("FAIL reset_enosc: got %0h expected 0", enosc); end
      checks++; if (sleep_b !== 1'b0) begin errors++; $display("FAIL reset_sleep_b: got %0b expected 0", sleep_b); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      checks++; if (cnt_valid !== 1'b0 || done !== 1'b0 || sel_err !== 1'b0) begin errors++; $display("FAIL reset_strobes: got valid=%0b done=%0b sel_err=%0b expected 0", cnt_valid, done, sel_err); end
      checks++; if (cnt_data !== '0 || cnt_sel !== '0 || cnt_ovf !== 1'b0) begin errors++; $display("FAIL reset_cnt: got data=%0d sel=%0d ovf=%0b expected 0", cnt_data, cnt_sel, cnt_ovf); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single;
      int vcyc = -1;
      osc_period = 10;
      osc_sel = 7'd5; win_len = 16'd100; sweep_mode = 1'b0;
      start = 1'b1;
      for (int c = 1; c <= 200; c++) begin
         tick();
         if (c == 1) begin
            start = 1'b0;
            osc_sel = 7'd9; win_len = 16'd3; sweep_mode = 1'b1;
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_t1: got %0b expected 1", busy); end
         end
         if (c == 3 || c == 50) begin
            checks++; if (enosc !== 63'h10) begin errors++; $display("FAIL single_enosc_c%0d: got %0h expected 10", c, enosc); end
         end
         if (cnt_valid) begin vcyc = c; break; end
      end
      checks++; if (vcyc !== 109) begin errors++; $display("FAIL single_latency: got %0d expected 109", vcyc); end
      checks++; if (cnt_data !== 16'd10) begin errors++; $display("FAIL single_data: got %0d expected 10", cnt_data); end
      checks++; if (cnt_sel !== 7'd5) begin errors++; $display("FAIL single_sel: got %0d expected 5", cnt_sel); end
      checks++; if (done !== 1'b1 || cnt_ovf !== 1'b0) begin errors++; $display("FAIL single_done_ovf: got done=%0b ovf=%0b expected done=1 ovf=0", done, cnt_ovf); end
      checks++; if (enosc !== '0 || sleep_b !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_report_ctl: got enosc=%0h sleep_b=%0b busy=%0b expected 0/1/1", enosc, sleep_b, busy); end
      tick();
      checks++; if (busy !== 1'b0 || sleep_b !== 1'b0 || cnt_valid !== 1'b0) begin errors++; $display("FAIL single_idle_after: got busy=%0b sleep_b=%0b valid=%0b expected 0", busy, sleep_b, cnt_valid); end
      checks++; if (cnt_data !== 16'd10 || cnt_sel !== 7'd5) begin errors++; $display("FAIL single_hold: got data=%0d sel=%0d expected 10/5", cnt_data, cnt_sel); end
      repeat (3) tick();
   endtask

   task automatic test_sweep;
      int rcyc[3] = '{-1, -1, -1};
      int rsel[3] = '{-1, -1, -1};
      int rdat[3] = '{-1, -1, -1};
      int rdone[3] = '{-1, -1, -1};
      int n = 0;
      int bad = 0;
      bit fin = 0;
      osc_period = 4;
      osc_sel = 7'd61; win_len = 16'd20; sweep_mode = 1'b1;
      start = 1'b1;
      for (int c = 1; c <= 200 && !fin; c++) begin
         tick();
         if (c == 1) start = 1'b0;
         if ($countones(enosc) > 1) bad++;
         if (cnt_valid) begin
            if (n < 3) begin
               rcyc[n] = c; rsel[n] = int'(cnt_sel); rdat[n] = int'(cnt_data); rdone[n] = int'(done);
            end
            n++;
         end
         if (done) fin = 1;
      end
      checks++; if (n !== 3) begin errors++; $display("FAIL sweep_count: got %0d results expected 3", n); end
      checks++; if (rcyc[0] !== 29) begin errors++; $display("FAIL sweep_first_latency: got %0d expected 29", rcyc[0]); end
      checks++; if (rcyc[1] - rcyc[0] !== 29 || rcyc[2] - rcyc[1] !== 29) begin errors++; $display("FAIL sweep_spacing: got %0d,%0d expected 29,29", rcyc[1] - rcyc[0], rcyc[2] - rcyc[1]); end
      checks++; if (rsel[0] !== 61 || rsel[1] !== 62 || rsel[2] !== 63) begin errors++; $display("FAIL sweep_sel: got %0d,%0d,%0d expected 61,62,63", rsel[0], rsel[1], rsel[2]); end
      checks++; if (rdat[0] !== 5 || rdat[1] !== 5 || rdat[2] !== 5) begin errors++; $display("FAIL sweep_data: got %0d,%0d,%0d expected 5,5,5", rdat[0], rdat[1], rdat[2]); end
      checks++; if (rdone[0] !== 0 || rdone[1] !== 0 || rdone[2] !== 1) begin errors++; $display("FAIL sweep_done: got %0d,%0d,%0d expected 0,0,1", rdone[0], rdone[1], rdone[2]); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL sweep_onehot: got %0d multi-hot cycles expected 0", bad); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sweep_idle_after: got busy=%0b expected 0", busy); end
      repeat (3) tick();
   endtask

   task automatic test_ovf;
      int vcyc = -1;
      osc_period = 4;
      osc_sel = 7'd3; win_len = 16'd100; sweep_mode = 1'b0;
      start = 1'b1;
      for (int c = 1; c <= 200; c++) begin
         tick();
         if (c == 1) start = 1'b0;
         if (cnt_valid4) begin vcyc = c; break; end
      end
      checks++; if (vcyc !== 109) begin errors++; $display("FAIL ovf_latency: got %0d expected 109", vcyc); end
      checks++; if (cnt_data4 !== 4'd15 || cnt_ovf4 !== 1'b1) begin errors++; $display("FAIL ovf_sat: got data=%0d ovf=%0b expected 15/1", cnt_data4, cnt_ovf4); end
      checks++; if (cnt_data !== 16'd25 || cnt_ovf !== 1'b0) begin errors++; $display("FAIL ovf_wide: got data=%0d ovf=%0b expected 25/0", cnt_data, cnt_ovf); end
      repeat (3) tick();
   endtask

   task automatic test_sel_err;
      logic [SEL_W-1:0] bad_sel [2] = '{7'd0, 7'd64};
      for (int k = 0; k < 2; k++) begin
         osc_sel = bad_sel[k]; sweep_mode = 1'b0; win_len = 16'd5;
         start = 1'b1;
         tick();
         start = 1'b0;
         checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL selerr_pulse_%0d: got %0b expected 1", bad_sel[k], sel_err); end
         checks++; if (busy !== 1'b0 || enosc !== '0) begin errors++; $display("FAIL selerr_idle_%0d: got busy=%0b enosc=%0h expected 0/0", bad_sel[k], busy, enosc); end
         tick();
         checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL selerr_single_%0d: got %0b expected 0", bad_sel[k], sel_err); end
      end
      osc_sel = 7'd0; start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL abort_start_bad: got sel_err=%0b expected 0", sel_err); end
      osc_sel = 7'd4; start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_good: got busy=%0b expected 0", busy); end
      repeat (2) tick();
   endtask

   task automatic test_abort;
      int vcyc = -1;
      int stray = 0;
      osc_period = 10;
      osc_sel = 7'd7; win_len = 16'd100; sweep_mode = 1'b0;
      start = 1'b1;
      for (int c = 1; c <= 58; c++) begin
         tick();
         if (c == 1) start = 1'b0;
         if (cnt_valid || done) stray++;
      end
      checks++; if (enosc !== 63'h40 || busy !== 1'b1) begin errors++; $display("FAIL abort_pre: got enosc=%0h busy=%0b expected 40/1", enosc, busy); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++; if (enosc !== '0 || sleep_b !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got enosc=%0h sleep_b=%0b busy=%0b expected 0", enosc, sleep_b, busy); end
      checks++; if (cnt_data !== 16'd25 || cnt_sel !== 7'd3) begin errors++; $display("FAIL abort_hold: got data=%0d sel=%0d expected 25/3", cnt_data, cnt_sel); end
      repeat (2) begin
         if (cnt_valid || done) stray++;
         tick();
      end
      checks++; if (stray !== 0) begin errors++; $display("FAIL abort_no_strobe: got %0d strobes expected 0", stray); end
      start = 1'b1;
      for (int c = 1; c <= 200; c++) begin
         tick();
         if (c == 1) start = 1'b0;
         if (cnt_valid) begin vcyc = c; break; end
      end
      checks++; if (vcyc !== 109) begin errors++; $display("FAIL abort_restart_latency: got %0d expected 109", vcyc); end
      checks++; if (cnt_data !== 16'd10 || cnt_sel !== 7'd7 || done !== 1'b1) begin errors++; $display("FAIL abort_restart_result: got data=%0d sel=%0d done=%0b expected 10/7/1", cnt_data, cnt_sel, done); end
      repeat (3) tick();
   endtask

   task automatic test_reset_mid;
      int vcyc = -1;
      osc_period = 4;
      osc_sel = 7'd1; win_len = 16'd20; sweep_mode = 1'b1;
      start = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (c == 1) start = 1'b0;
      end
      checks++; if (busy !== 1'b1 || cnt_data !== 16'd5) begin errors++; $display("FAIL rstmid_pre: got busy=%0b data=%0d expected 1/5", busy, cnt_data); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (enosc !== '0 || sleep_b !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_ctl: got enosc=%0h sleep_b=%0b busy=%0b expected 0", enosc, sleep_b, busy); end
      checks++; if (cnt_data !== '0 || cnt_sel !== '0 || cnt_valid !== 1'b0) begin errors++; $display("FAIL rstmid_cnt: got data=%0d sel=%0d valid=%0b expected 0", cnt_data, cnt_sel, cnt_valid); end
      osc_period = 0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      osc_sel = 7'd2; win_len = 16'd0; sweep_mode = 1'b0;
      start = 1'b1;
      for (int c = 1; c <= 50; c++) begin
         tick();
         if (c == 1) start = 1'b0;
         if (cnt_valid) begin vcyc = c; break; end
      end
      checks++; if (vcyc !== 10) begin errors++; $display("FAIL rstmid_win0_latency: got %0d expected 10", vcyc); end
      checks++; if (cnt_data !== 16'd0 || cnt_sel !== 7'd2 || done !== 1'b1 || cnt_ovf !== 1'b0) begin errors++; $display("FAIL rstmid_win0_result: got data=%0d sel=%0d done=%0b ovf=%0b expected 0/2/1/0", cnt_data, cnt_sel, done, cnt_ovf); end
      repeat (2) tick();
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; sweep_mode = 1'b0;
      osc_sel = '0; win_len = '0; osc = 1'b0;
      test_reset();
      test_single();
      test_sweep();
      test_ovf();
      test_sel_err();
      test_abort();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

endmodule

// File: doc/idv_osc_meas_ctl.md
Name: idv_osc_meas_ctl

Overview:
- Parametrised successor to the fixed 63-oscillator IDV bank. Drives the bank's one-hot oscillator enables and sleep control.
- Counts edges of the bank's pre-divided oscillator output over a programmable window of reference clocks, and reports the count for each oscillator.
- Supports single-oscillator and sweep modes. Sits between the IDV debug register block and the oscillator bank.

Parameters:
- NOSC, 63: number of oscillators in the bank; enables are indexed 1..NOSC.
- SEL_W, 7: oscillator select width; must satisfy 2^SEL_W > NOSC.
- CNT_W, 16: edge counter width.
- WIN_W, 16: measurement window length width.
- SETTLE_CYC, 8: oscillator warm-up cycles after enable; must be >= SYNC_STAGES+1.
- SYNC_STAGES, 2: synchroniser depth on osc_div_in.

Ports:
- idvdebug_clki  in  1  reference clock; all state rises on this edge.
- idvrst_b  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- abort  in  1  terminate the current operation.
- sweep_mode  in  1  0 = measure osc_sel only; 1 = measure osc_sel..NOSC in turn.
- osc_sel  in  SEL_W  first (or only) oscillator index.
- win_len  in  WIN_W  window length in clocks; 0 is treated as 1.
- osc_div_in  in  1  divided bank output, asynchronous; frequency must be < clk/2.
- enosc  out  NOSC  one-hot oscillator enable; bit i-1 enables oscillator i.
- sleep_b  out  1  bank awake (active high).
- busy  out  1  operation in progress.
- cnt_valid  out  1  single-cycle result strobe.
- cnt_data  out  CNT_W  edge count.
- cnt_sel  out  SEL_W  oscillator index for cnt_data.
- cnt_ovf  out  1  counter saturated during this window.
- done  out  1  pulse on the final result of an operation.
- sel_err  out  1  pulse when start is rejected for a bad index.

Behaviour:
- Reset values: all outputs 0 (enosc=0, sleep_b=0, busy=0, cnt_*=0, done=0, sel_err=0). FSM=IDLE; synchroniser and counters cleared.
- FSM states: IDLE, SETTLE, MEASURE, REPORT.
- Start decode (IDLE only):
  - start=1 with 1<=osc_sel<=NOSC: latch osc_sel as cur, latch sweep_mode and win_len; next state SETTLE.
  - start=1 with osc_sel=0 or osc_sel>NOSC: sel_err=1 for one cycle, remain in IDLE.
  - start while busy=1: ignored.
- SETTLE:
  - Lasts exactly SETTLE_CYC cycles.
  - enosc = onehot(cur), sleep_b=1, busy=1.
  - Edges are ignored; the synchroniser runs freely.
- MEASURE:
  - Lasts max(win_len,1) cycles; enosc and sleep_b unchanged.
  - Edge counter is cleared on entry.
  - Increments by 1 on each cycle where sync_out=1 and prev=0 (rising edge after the synchroniser).
  - On reaching 2^CNT_W-1 the counter saturates and sets the ovf flag.
- REPORT (1 cycle):
  - cnt_valid=1, cnt_data=count, cnt_sel=cur, cnt_ovf=ovf. enosc=0; sleep_b stays 1.
  - If sweep and cur<NOSC: cur+=1, next state SETTLE.
  - Otherwise: done=1 in this same cycle, next state IDLE.
- IDLE: enosc=0, sleep_b=0, busy=0.
- Output holding: cnt_data, cnt_sel and cnt_ovf hold their last value until the next REPORT.
- Latency: start at cycle T gives cnt_valid at T+SETTLE_CYC+max(win_len,1)+1. busy is 1 from T+1 through the REPORT cycle inclusive.
- Sweep timing: consecutive results are spaced SETTLE_CYC+max(win_len,1)+1 cycles apart. enosc is 0 for exactly one cycle (REPORT) between oscillators, so enosc is never more than one-hot.
- Abort:
  - In any non-IDLE state, abort=1 forces IDLE next cycle.
  - enosc=0 and sleep_b=0 next cycle.
  - No cnt_valid and no done are produced; cnt_* outputs keep their previous values.
  - abort in REPORT suppresses the sweep continuation, but the cnt_valid of that cycle still fires.
  - abort and start together in IDLE: abort wins, start is ignored, no sel_err.
- Reset mid-operation: immediate return to reset values. A partial count is never reported.
- Sweep starting at osc_sel=NOSC produces exactly one result, with done.
- Accepted inputs: win_len, sweep_mode and osc_sel changes after start are ignored until the next start.

Test Plan:
- NOSC=63, SETTLE_CYC=8, win_len=100, osc_sel=5, osc_div_in period 10 clocks, phase-locked -> enosc=0x10 during SETTLE/MEASURE; cnt_valid at T+109; cnt_data=10, cnt_sel=5, done=1, cnt_ovf=0.
- Sweep with osc_sel=61, win_len=20, period 4 -> three results cnt_sel=61,62,63, cnt_data=5 each, spaced 29 cycles apart; done only with cnt_sel=63; enosc never has two bits set.
- CNT_W=4, win_len=100, period 4 -> cnt_data=15, cnt_ovf=1.
- start with osc_sel=0, and again with osc_sel=64 -> sel_err pulse each time, busy stays 0, enosc stays 0.
- abort in MEASURE cycle 50 of a window of 100 -> IDLE next cycle, enosc=0, sleep_b=0, no cnt_valid/done. A start 2 cycles later is accepted normally.
- idvrst_b low mid-sweep -> all outputs 0 asynchronously. After release, a start measures from a cleared count with win_len=0 -> cnt_valid at T+SETTLE_CYC+2.
